full_st0_out_buffer: RTL and testbench



---
 rtl/full_st0_out_buffer.sv | 104 ++++++++++
 tb/tb_full_st0_out_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/full_st0_out_buffer.sv
// Elastic first-word-fall-through buffer between stage-0 and stage-1.
// Tags every stored word with a last marker derived from the programmed frame length.
module full_st0_out_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int LEN_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LEN_W-1:0]           frame_length,
  input  logic [WIDTH-1:0]           stage_0_data_out,
  input  logic                       stage_0_data_out_fst,
  input  logic                       stage_0_data_out_vld,
  output logic                       stage_0_data_out_rdy,
  output logic [WIDTH-1:0]           stage_1_data,
  output logic                       stage_1_data_fst,
  output logic                       stage_1_data_lst,
  output logic                       stage_1_data_vld,
  input  logic                       stage_1_data_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_done,
  output logic                       frame_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH+1:0] head;
  logic             push, pop;
  state_t           state;
  logic [LEN_W-1:0] len_q, in_cnt;
  logic [LEN_W:0]   cnt_next;
  logic             lst_in;

  // A programmed length of zero stands for the full 2^LEN_W range.
  function automatic logic [LEN_W:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  endfunction

  assign stage_0_data_out_rdy = (level != (AW+1)'(DEPTH));
  assign stage_1_data_vld     = (level != '0);
  assign push = stage_0_data_out_vld & stage_0_data_out_rdy;
  assign pop  = stage_1_data_vld & stage_1_data_rdy;

  assign head             = mem[rd_ptr];
  assign stage_1_data     = head[WIDTH-1:0];
  assign stage_1_data_fst = head[WIDTH];
  assign stage_1_data_lst = head[WIDTH+1];

  assign cnt_next = {1'b0, in_cnt} + (LEN_W+1)'(1);

  always_comb begin
    lst_in = 1'b0;
    if (stage_0_data_out_fst)
      lst_in = (eff_len(frame_length) == (LEN_W+1)'(1));
    else if (state == IN_FRAME)
      lst_in = (cnt_next == eff_len(len_q));
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {lst_in, stage_0_data_out_fst, stage_0_data_out};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      in_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= pop & head[WIDTH+1];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      // Frame checker only moves on accepted words; a premature fst restarts the count.
      if (push) begin
        if (stage_0_data_out_fst) begin
          if (state == IN_FRAME) frame_err <= 1'b1;
          len_q  <= frame_length;
          in_cnt <= LEN_W'(1);
          state  <= lst_in ? IDLE : IN_FRAME;
        end else if (state == IDLE) begin
          frame_err <= 1'b1;
        end else begin
          in_cnt <= cnt_next[LEN_W-1:0];
          if (lst_in) state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_st0_out_buffer.sv
// Directed bench for full_st0_out_buffer: flow, backpressure, framing, edge lengths, reset.
module tb_full_st0_out_buffer;

  logic        clk;
  logic        reset;
  logic [5:0]  frame_length;
  logic [31:0] in_data;
  logic        in_fst;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] out_data;
  logic        out_fst;
  logic        out_lst;
  logic        out_vld;
  logic        out_rdy;
  logic [3:0]  level;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  full_st0_out_buffer #(.DEPTH(8), .WIDTH(32), .LEN_W(6)) dut (
    .clk                  (clk),
    .reset                (reset),
    .frame_length         (frame_length),
    .stage_0_data_out     (in_data),
    .stage_0_data_out_fst (in_fst),
    .stage_0_data_out_vld (in_vld),
    .stage_0_data_out_rdy (in_rdy),
    .stage_1_data         (out_data),
    .stage_1_data_fst     (out_fst),
    .stage_1_data_lst     (out_lst),
    .stage_1_data_vld     (out_vld),
    .stage_1_data_rdy     (out_rdy),
    .level                (level),
    .frame_done           (frame_done),
    .frame_err            (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    in_vld = 1'b0;
    in_fst = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [31:0] d, input logic f);
    in_vld  = 1'b1;
    in_data = d;
    in_fst  = f;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'h3F800000;
    words[1] = 32'h40000000;
    words[2] = 32'h40400000;
    words[3] = 32'h40800000;
    reset = 1'b0; frame_length = 6'd4; in_data = '0; in_fst = 1'b0;
    in_vld = 1'b0; out_rdy = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk ("rst_level", 32'(level), 32'd0);
    chkb("rst_vld", out_vld, 1'b0);
    chkb("rst_rdy", in_rdy, 1'b1);
    chkb("rst_done", frame_done, 1'b0);
    chkb("rst_err", frame_err, 1'b0);

    // Basic flow, length 4, downstream always ready
    frame_length = 6'd4; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(words[i], i == 0);
      step();
      chkb("flow_vld", out_vld, 1'b1);
      chk ("flow_data", out_data, words[i]);
      chkb("flow_fst", out_fst, i == 0);
      chkb("flow_lst", out_lst, i == 3);
      chk ("flow_level", 32'(level), 32'd1);
      chkb("flow_done_lo", frame_done, 1'b0);
    end
    in_vld = 1'b0;
    step();
    chkb("flow_done_hi", frame_done, 1'b1);
    chkb("flow_empty", out_vld, 1'b0);
    step();
    chkb("flow_done_once", frame_done, 1'b0);
    chkb("flow_err", frame_err, 1'b0);

    // Backpressure until full
    do_reset();
    frame_length = 6'd0; out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chkb("bp_rdy_open", in_rdy, 1'b1);
      drive(32'h100 + 32'(i), i == 0);
      step();
    end
    chk ("bp_level_full", 32'(level), 32'd8);
    chkb("bp_rdy_full", in_rdy, 1'b0);
    drive(32'h108, 1'b0);
    step();
    chk ("bp_level_hold", 32'(level), 32'd8);
    chk ("bp_head_hold", out_data, 32'h100);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chkb("bp_rdy_reopen", in_rdy, 1'b1);
    chk ("bp_level_7", 32'(level), 32'd7);
    step();
    in_vld = 1'b0;
    chk ("bp_level_refill", 32'(level), 32'd8);
    out_rdy = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk("bp_order", out_data, 32'h100 + 32'(i));
      step();
    end
    chk ("bp_drained", 32'(level), 32'd0);

    // Steady push/pop at level 3 across pointer wraps
    do_reset();
    frame_length = 6'd0; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + 32'(i), i == 0);
      step();
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h203 + 32'(i), 1'b0);
      chk("pp_level", 32'(level), 32'd3);
      chk("pp_data", out_data, 32'h200 + 32'(i));
      step();
    end
    in_vld = 1'b0;
    chk ("pp_level_end", 32'(level), 32'd3);
    chk ("pp_data_end", out_data, 32'h214);

    // Non-fst word out of IDLE
    do_reset();
    out_rdy = 1'b1;
    drive(32'hDEAD, 1'b0);
    step();
    in_vld = 1'b0;
    chkb("err_nofst", frame_err, 1'b1);
    chkb("err_nofst_lst", out_lst, 1'b0);
    step();
    chkb("err_sticky", frame_err, 1'b1);

    // Premature fst on the third word of a length-4 frame
    do_reset();
    frame_length = 6'd4; out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(32'h300 + 32'(i), (i == 0) || (i == 2));
      step();
      chkb("pre_lst", out_lst, i == 5);
      chkb("pre_err", frame_err, i >= 2);
    end
    in_vld = 1'b0;
    step();

    // Length 1: every word is both first and last
    do_reset();
    frame_length = 6'd1; out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h400 + 32'(i), 1'b1);
      step();
      chkb("len1_fst", out_fst, 1'b1);
      chkb("len1_lst", out_lst, 1'b1);
      chkb("len1_done", frame_done, i > 0);
    end
    in_vld = 1'b0;
    step();
    chkb("len1_done_last", frame_done, 1'b1);
    chkb("len1_err", frame_err, 1'b0);

    // Length 0 means 64 words
    frame_length = 6'd0;
    for (int i = 0; i < 64; i++) begin
      drive(32'h500 + 32'(i), i == 0);
      step();
      chkb("len64_lst", out_lst, i == 63);
    end
    in_vld = 1'b0;
    step();
    chkb("len64_done", frame_done, 1'b1);
    chkb("len64_err", frame_err, 1'b0);

    // Reset with five words buffered and the error flag raised
    frame_length = 6'd4; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h600 + 32'(i), 1'b0);
      step();
    end
    in_vld = 1'b0;
    chk ("mid_level5", 32'(level), 32'd5);
    chkb("mid_err_set", frame_err, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk ("mid_level", 32'(level), 32'd0);
    chkb("mid_vld", out_vld, 1'b0);
    chkb("mid_rdy", in_rdy, 1'b1);
    chkb("mid_err", frame_err, 1'b0);
    frame_length = 6'd2; out_rdy = 1'b1;
    drive(32'h700, 1'b1);
    step();
    chk ("mid_new0", out_data, 32'h700);
    chkb("mid_new0_fst", out_fst, 1'b1);
    chkb("mid_new0_lst", out_lst, 1'b0);
    drive(32'h701, 1'b0);
    step();
    in_vld = 1'b0;
    chk ("mid_new1", out_data, 32'h701);
    chkb("mid_new1_lst", out_lst, 1'b1);
    step();
    chkb("mid_done", frame_done, 1'b1);
    chkb("mid_err_end", frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
